seg_display_arbiter: RTL and testbench

Shares the 8-digit seven-segment display among up to NUM_REQ requesters: FSM status, error countdown, bonus cycle counter and menu text. Each requester presents a complete pre-encoded 64-bit frame. The block grants one owner by fixed priority with a minimum hold time, double-buffers the owner's frame, and drives the multiplexed scan of the two 4-digit groups. It sits between the display-content generators and the board's seg_out0/seg_out1/seg_an pins.

---
 rtl/seg_arb_pkg.sv | 65 ++++++
 rtl/seg_display_arbiter_scan.sv | 42 ++++
 rtl/seg_display_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// Shared types and glyph encodings for the seven-segment display arbiter.
// Glyph byte order MSB->LSB is a b c d e f g dp, active high.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_e;

    localparam int DIGITS  = 8;
    localparam int SEG_W   = 8;
    localparam int FRAME_W = DIGITS * SEG_W;

    localparam logic [SEG_W-1:0] CHAR_BLANK = 8'h00;
    localparam logic [SEG_W-1:0] CHAR_DASH  = 8'h02;
    localparam logic [SEG_W-1:0] CHAR_0     = 8'hFC;
    localparam logic [SEG_W-1:0] CHAR_1     = 8'h60;
    localparam logic [SEG_W-1:0] CHAR_2     = 8'hDA;
    localparam logic [SEG_W-1:0] CHAR_3     = 8'hF2;
    localparam logic [SEG_W-1:0] CHAR_4     = 8'h66;
    localparam logic [SEG_W-1:0] CHAR_5     = 8'hB6;
    localparam logic [SEG_W-1:0] CHAR_6     = 8'hBE;
    localparam logic [SEG_W-1:0] CHAR_7     = 8'hE0;
    localparam logic [SEG_W-1:0] CHAR_8     = 8'hFE;
    localparam logic [SEG_W-1:0] CHAR_9     = 8'hF6;
    localparam logic [SEG_W-1:0] CHAR_A     = 8'hEE;
    localparam logic [SEG_W-1:0] CHAR_B     = 8'h3E;
    localparam logic [SEG_W-1:0] CHAR_C     = 8'h9C;
    localparam logic [SEG_W-1:0] CHAR_D     = 8'h7A;
    localparam logic [SEG_W-1:0] CHAR_E     = 8'h9E;
    localparam logic [SEG_W-1:0] CHAR_F     = 8'h8E;
    localparam logic [SEG_W-1:0] CHAR_H     = 8'h6E;
    localparam logic [SEG_W-1:0] CHAR_L     = 8'h1C;
    localparam logic [SEG_W-1:0] CHAR_N     = 8'h2A;
    localparam logic [SEG_W-1:0] CHAR_O     = 8'h3A;
    localparam logic [SEG_W-1:0] CHAR_P     = 8'hCE;
    localparam logic [SEG_W-1:0] CHAR_R     = 8'h0A;
    localparam logic [SEG_W-1:0] CHAR_U     = 8'h7C;

    // Hex nibble to glyph, for requesters that show counters.
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] value);
        logic [SEG_W-1:0] glyph;
        unique case (value)
            4'h0:    glyph = CHAR_0;
            4'h1:    glyph = CHAR_1;
            4'h2:    glyph = CHAR_2;
            4'h3:    glyph = CHAR_3;
            4'h4:    glyph = CHAR_4;
            4'h5:    glyph = CHAR_5;
            4'h6:    glyph = CHAR_6;
            4'h7:    glyph = CHAR_7;
            4'h8:    glyph = CHAR_8;
            4'h9:    glyph = CHAR_9;
            4'hA:    glyph = CHAR_A;
            4'hB:    glyph = CHAR_B;
            4'hC:    glyph = CHAR_C;
            4'hD:    glyph = CHAR_D;
            4'hE:    glyph = CHAR_E;
            default: glyph = CHAR_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_scan.sv
// Scan timer: SCAN_DIV-cycle slot divider plus digit-pair index 0..3.
// round_end_o is high in the last cycle of slot 3, i.e. the last cycle of a refresh round.
module seg_scan_timer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx_o,
    output logic       round_end_o
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign round_end_o = (div_q == DIV_LAST) && (idx_q == 2'd3);

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority, hold-time arbiter sharing an 8-digit seven-segment display, with
// double-buffered tear-free frames. Optional blink support under `SEG_ARB_BLINK_EN.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [FRAME_W*NUM_REQ-1:0] frame_flat,
    input  logic [NUM_REQ-1:0]         req_blink,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       frame_swap,
    output logic [SEG_W-1:0]           seg_out0,
    output logic [SEG_W-1:0]           seg_out1,
    output logic [DIGITS-1:0]          seg_an
);

    localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [FRAME_W-1:0]  shadow_q, shadow_d;
    logic [FRAME_W-1:0]  active_q;
    logic                frame_swap_q;
    logic [SEG_W-1:0]    seg_out0_q, seg_out1_q;
    logic [DIGITS-1:0]   seg_an_q;

    logic                req_any;
    logic [IDX_W-1:0]    req_low;
    logic                rearb;
    logic [1:0]          scan_idx;
    logic                round_end;
    logic [3:0]          an4;
    logic                blank_force;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (scan_idx),
        .round_end_o (round_end)
    );

    // Lowest set index wins; scanning downward leaves the lowest one as the last write.
    always_comb begin
        req_any = 1'b0;
        req_low = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_any = 1'b1;
                req_low = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        rearb      = 1'b0;
        unique case (state_q)
            ST_IDLE: rearb = req_any;
            ST_HOLD: begin
                if (!req[owner_q]) begin
                    rearb = 1'b1;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_OPEN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_OPEN: rearb = !req[owner_q] || (req_any && (req_low < owner_q));
            default: state_d = ST_IDLE;
        endcase
        // Owner drop and preemption share one path: pick the best remaining requester.
        if (rearb) begin
            if (req_any) begin
                state_d    = ST_HOLD;
                owner_d    = req_low;
                hold_cnt_d = HOLD_INIT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        gnt_d = '0;
        if (state_d != ST_IDLE) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_comb begin
        shadow_d = '0;
        if (state_q != ST_IDLE) begin
            shadow_d = frame_flat[FRAME_W*int'(owner_q) +: FRAME_W];
        end
    end

`ifdef SEG_ARB_BLINK_EN
    localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               shadow_blink_q, shadow_blink_d;
    logic               active_blink_q;

    always_comb begin
        blink_cnt_d    = blink_cnt_q + 1'b1;
        phase_d        = phase_q;
        shadow_blink_d = (state_q != ST_IDLE) && req_blink[owner_q];
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            shadow_blink_q <= 1'b0;
            active_blink_q <= 1'b0;
        end else begin
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            shadow_blink_q <= shadow_blink_d;
            if (round_end) begin
                active_blink_q <= shadow_blink_q;
            end
        end
    end

    assign blank_force = active_blink_q & phase_q;
`else
    logic unused_blink;
    assign unused_blink = ^req_blink ^ (BLINK_DIV > 0);
    assign blank_force  = 1'b0;
`endif

    // The same one-hot nibble lights digit idx in each group.
    assign an4 = 4'b0001 << scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            hold_cnt_q   <= '0;
            gnt_q        <= '0;
            // NOTE: the frame buffers are wide but still reset, so the display is dark rather than random out of reset.
            shadow_q     <= '0;
            active_q     <= '0;
            frame_swap_q <= 1'b0;
            seg_an_q     <= '0;
            seg_out0_q   <= '0;
            seg_out1_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_q        <= gnt_d;
            shadow_q     <= shadow_d;
            if (round_end) begin
                active_q <= shadow_q;
            end
            frame_swap_q <= round_end;
            seg_an_q     <= {an4, an4};
            seg_out0_q   <= blank_force ? '0 : active_q[SEG_W*int'(scan_idx) +: SEG_W];
            seg_out1_q   <= blank_force ? '0 : active_q[SEG_W*(int'(scan_idx) + 4) +: SEG_W];
        end
    end

    assign gnt        = gnt_q;
    assign frame_swap = frame_swap_q;
    assign seg_an     = seg_an_q;
    assign seg_out0   = seg_out0_q;
    assign seg_out1   = seg_out1_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed self-checking bench for seg_display_arbiter (SCAN_DIV=4, HOLD_CYCLES=8, BLINK_DIV=16).
module tb_seg_display_arbiter;
    import seg_arb_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int SCAN_DIV    = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int BLINK_DIV   = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   req_blink = '0;
    logic [255:0] frame_flat = '0;
    logic [3:0]   gnt;
    logic         frame_swap;
    logic [7:0]   seg_out0, seg_out1, seg_an;

    int n_cmp = 0;
    int n_bad = 0;

    // Digits 0..7 = 0 1 2 3 4 5 6 7 and A b C d E F H L, hand-encoded.
    logic [63:0] frame_a = {8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};
    logic [63:0] frame_b = {8'h1C, 8'h6E, 8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE};
    logic [7:0]  exp_a0 [4] = '{8'hFC, 8'h60, 8'hDA, 8'hF2};
    logic [7:0]  exp_a1 [4] = '{8'h66, 8'hB6, 8'hBE, 8'hE0};

    seg_display_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .frame_flat (frame_flat),
        .req_blink  (req_blink),
        .gnt        (gnt),
        .frame_swap (frame_swap),
        .seg_out0   (seg_out0),
        .seg_out1   (seg_out1),
        .seg_an     (seg_an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_swap(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (frame_swap === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_swap: frame_swap not seen in 40 cycles, want one pulse", tag);
        end
    endtask

    task automatic test_reset();
        logic [7:0] want_an;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({gnt, frame_swap, seg_an, seg_out0, seg_out1} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got gnt=%b swap=%b an=%h o0=%h o1=%h want all 0",
                     gnt, frame_swap, seg_an, seg_out0, seg_out1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            want_an = 8'h11 << (c / 4);
            n_cmp++;
            if (seg_an !== want_an) begin
                n_bad++;
                $display("FAIL reset_scan_an[%0d]: got %h want %h", c, seg_an, want_an);
            end
            n_cmp++;
            if ({seg_out0, seg_out1} !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_scan_seg[%0d]: got %h/%h want 00/00", c, seg_out0, seg_out1);
            end
        end
        // Reset asserted in the middle of a round, away from any clock edge.
        frame_flat[128 +: 64] = frame_a;
        req = 4'b0100;
        repeat (6) tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_pre_gnt: got %b want 0100", gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, frame_swap, seg_an, seg_out0, seg_out1} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_async: got gnt=%b swap=%b an=%h o0=%h o1=%h want all 0",
                     gnt, frame_swap, seg_an, seg_out0, seg_out1);
        end
        @(negedge clk);
        req        = '0;
        frame_flat = '0;
        rst_n      = 1'b1;
        tick();
        n_cmp++;
        if ({gnt, seg_an, seg_out0, seg_out1} !== {4'b0000, 8'h11, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_first: got gnt=%b an=%h o0=%h o1=%h want 0000/11/00/00",
                     gnt, seg_an, seg_out0, seg_out1);
        end
    endtask

    task automatic test_single();
        frame_flat[128 +: 64] = frame_a;
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        tick();
        wait_swap("single");
        tick();
        n_cmp++;
        if (frame_swap !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse: frame_swap got %b want 0", frame_swap);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({seg_an, seg_out0, seg_out1} !== {8'h11 << k, exp_a0[k], exp_a1[k]}) begin
                n_bad++;
                $display("FAIL single_digit[%0d]: got an=%h o0=%h o1=%h want an=%h o0=%h o1=%h",
                         k, seg_an, seg_out0, seg_out1, 8'h11 << k, exp_a0[k], exp_a1[k]);
            end
            if (k < 3) repeat (4) tick();
        end
    endtask

    task automatic test_priority();
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL prio_idle: got %b want 0000", gnt);
        end
        frame_flat[192 +: 64] = frame_b;
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_bad++;
            $display("FAIL prio_grant: got %b want 1000", gnt);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b1000) begin
                n_bad++;
                $display("FAIL prio_hold[%0d]: got %b want 1000", k, gnt);
            end
            if (k == 2) req = 4'b1001;
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL prio_preempt: got %b want 0001", gnt);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0001) begin
                n_bad++;
                $display("FAIL prio_keep[%0d]: got %b want 0001", k, gnt);
            end
        end
    endtask

    task automatic test_owner_drop();
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL drop_idle: got %b want 0000", gnt);
        end
        frame_flat[64 +: 64] = frame_b;
        req = 4'b0110;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL drop_first: got %b want 0010", gnt);
        end
        repeat (2) tick();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL drop_handover: got %b want 0100", gnt);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL drop_release: got %b want 0000", gnt);
        end
        tick();
        wait_swap("drop");
        for (int c = 0; c < 16; c++) begin
            tick();
            n_cmp++;
            if ({seg_out0, seg_out1} !== 16'h0000) begin
                n_bad++;
                $display("FAIL drop_blank[%0d]: got %h/%h want 00/00", c, seg_out0, seg_out1);
            end
        end
    endtask

    task automatic test_tear_free();
        frame_flat[0 +: 64] = frame_a;
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL tear_gnt: got %b want 0001", gnt);
        end
        tick();
        wait_swap("tear_old");
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({seg_an, seg_out0, seg_out1} !== {8'h11 << k, exp_a0[k], exp_a1[k]}) begin
                n_bad++;
                $display("FAIL tear_old[%0d]: got an=%h o0=%h o1=%h want an=%h o0=%h o1=%h",
                         k, seg_an, seg_out0, seg_out1, 8'h11 << k, exp_a0[k], exp_a1[k]);
            end
            if (k == 1) frame_flat[0 +: 64] = frame_b;
            if (k < 3) repeat (4) tick();
        end
        wait_swap("tear_new");
        tick();
        n_cmp++;
        if ({seg_an, seg_out0, seg_out1} !== {8'h11, 8'hEE, 8'h9E}) begin
            n_bad++;
            $display("FAIL tear_new0: got an=%h o0=%h o1=%h want 11/EE/9E", seg_an, seg_out0, seg_out1);
        end
        repeat (4) tick();
        n_cmp++;
        if ({seg_an, seg_out0, seg_out1} !== {8'h22, 8'h3E, 8'h8E}) begin
            n_bad++;
            $display("FAIL tear_new1: got an=%h o0=%h o1=%h want 22/3E/8E", seg_an, seg_out0, seg_out1);
        end
    endtask

    task automatic test_blink();
        int blank = 0;
        int run = 0;
        int max_run = 0;
        int want_blank;
        int want_run;
`ifdef SEG_ARB_BLINK_EN
        want_blank = 32;
        want_run   = 16;
`else
        want_blank = 0;
        want_run   = 0;
`endif
        req_blink = 4'b0001;
        tick();
        wait_swap("blink");
        tick();
        for (int c = 0; c < 64; c++) begin
            tick();
            if ({seg_out0, seg_out1} === 16'h0000) begin
                blank++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (blank != want_blank) begin
            n_bad++;
            $display("FAIL blink_count: got %0d blank cycles of 64, want %0d", blank, want_blank);
        end
        n_cmp++;
        if (max_run != want_run) begin
            n_bad++;
            $display("FAIL blink_run: got longest blank run %0d, want %0d", max_run, want_run);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_owner_drop();
        test_tear_free();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
